uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); only used when UART_RX_PARITY_EN is defined.
REQ-006 SHALL have port sys_clk, input, 1, the single clock.
REQ-007 SHALL have port sys_rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port po_data, output, DATA_BITS, received word, LSB first on the line.
REQ-010 SHALL have port po_valid, output, 1, po_data holds an unconsumed word.
REQ-011 SHALL have port po_ready, input, 1, consumer accepts the word when po_valid and po_ready are both high.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.
REQ-013 SHALL have port parity_err, output, 1, one-cycle pulse when the parity check fails.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a good word is dropped.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1, before any use.
REQ-017 SHALL compute BIT_CNT_MAX = CLK_FREQ/BAUD_RATE (integer division) and BIT_CNT_HALF = BIT_CNT_MAX/2; the baud counter SHALL count 0..BIT_CNT_MAX-1 and wrap.
REQ-018 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE SHALL go to START on a synchronized falling edge; a line already low when reset is released SHALL also count as a falling edge.
REQ-020 START SHALL sample the line at BIT_CNT_HALF: low goes to DATA; high is a glitch and returns to IDLE with no flags.
REQ-021 DATA SHALL sample each bit at mid-bit (one BIT_CNT_MAX after the previous sample), shifting LSB first, for exactly DATA_BITS samples.
REQ-022 After DATA, the block SHALL go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-023 STOP SHALL sample STOP_BITS bits; any low sample SHALL raise frame_err for one cycle, discard the word, and return to IDLE after the last stop sample.
REQ-024 A good word SHALL appear at po_data/po_valid in the cycle after the last stop-bit sample.
REQ-025 The single-entry holding register SHALL keep po_data stable while po_valid is high and po_ready is low; po_valid SHALL clear in the cycle after the handshake.
REQ-026 A good word completing while the holding register is full SHALL be dropped, with an overrun pulse, and po_data left unchanged.
REQ-027 A handshake in the same cycle as a new word completing SHALL load the new word, keep po_valid high, and raise no overrun.
REQ-028 Error and overrun pulses SHALL never coincide with a po_valid rising edge for the same frame.

Reset
REQ-029 sys_rst SHALL be sampled on the sys_clk rising edge only.
REQ-030 Reset SHALL clear po_data=0, po_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE, counters=0, synchronizer=1.
REQ-031 Reset mid-frame SHALL abandon the partial word with no flag pulse.

Configuration
REQ-032 When macro UART_RX_PARITY_EN is defined, the block SHALL sample one parity bit after DATA, check it against the XOR of the data bits (inverted when PARITY_ODD=1), and on mismatch pulse parity_err and discard the word.
REQ-033 When UART_RX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and parity_err SHALL be tied to 0.

Verification (CLK_FREQ=500_000 giving BIT_CNT_MAX=52, i.e. 1040 ns/bit at 20 ns clock; 8N1 unless stated)
REQ-034 Send 0x55 with po_ready=1 -> one-cycle po_valid with po_data=0x55; frame_err, parity_err and overrun stay 0.
REQ-035 Pulse rx low for 10 cycles, then high -> START aborts to IDLE and po_valid stays 0 for the following 20 bit times.
REQ-036 Send 0xA3 with the stop bit driven 0 -> frame_err pulses once; po_valid stays 0; the next frame 0x3C is received correctly.
REQ-037 With po_ready=0, send 0x12 then 0x34 -> po_data holds 0x12; overrun pulses at the 0x34 stop sample; raising po_ready clears po_valid one cycle later.
REQ-038 With UART_RX_PARITY_EN defined and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulses and the word is discarded; resend with parity bit 1 -> po_data=0x07.
REQ-039 Assert sys_rst for 1 cycle during data bit 4 -> all outputs read 0 next cycle; a subsequent frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop sync, mid-bit sampling, 1-entry holding reg.
// Optional parity check is built when macro UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_valid,
  input  logic                 po_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BIT_CNT_MAX  = CLK_FREQ / BAUD_RATE;
  localparam int BIT_CNT_HALF = BIT_CNT_MAX / 2;
  localparam int CNT_W        = $clog2(BIT_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BIT_CNT_HALF);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_ODD = 1'(PARITY_ODD);
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 valid_q, ferr_q, ovr_q, busy_q;
  logic                 stop_bad_q;
  logic                 tick_bit, tick_mid, fall;
  logic                 stop_low, par_bad, good;

  assign tick_bit = (cnt_q == CNT_LAST);
  assign tick_mid = (cnt_q == CNT_MID);
  assign cnt_d    = tick_bit ? '0 : cnt_q + 1'b1;
  // prev resets high, so a line held low through reset reads as an edge
  assign fall     = rx_prev_q & ~rx_s2_q;
  assign stop_low = stop_bad_q | ~rx_s2_q;
  assign good     = ~stop_low & ~par_bad;

`ifdef UART_RX_PARITY_EN
  logic perr_q, par_bad_q;
  assign par_bad    = par_bad_q;
  assign parity_err = perr_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (state_q == DATA && tick_bit && bit_q == DATA_LAST)
        par_bad_q <= 1'b0;
      if (state_q == PARITY && tick_bit)
        par_bad_q <= ((^shift_q) ^ PAR_ODD) != rx_s2_q;
      if (state_q == STOP && tick_bit && bit_q == STOP_LAST)
        perr_q <= par_bad_q;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= cnt_d;
      if (valid_q && po_ready)
        valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (fall) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick_mid) begin
            cnt_q <= '0;
            if (rx_s2_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (tick_bit) begin
            shift_q <= {rx_s2_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_q      <= '0;
              stop_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state_q    <= PARITY;
`else
              state_q    <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_bit)
            state_q <= STOP;
        end
`endif
        STOP: begin
          if (tick_bit) begin
            if (bit_q == STOP_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              bit_q   <= '0;
              ferr_q  <= stop_low;
              // a same-cycle handshake frees the slot for the new word
              if (good) begin
                if (!valid_q || po_ready) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end else begin
              bit_q      <= bit_q + 4'd1;
              stop_bad_q <= stop_low;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign po_data   = data_q;
  assign po_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param at 52 clocks per bit, 8 data bits, 1 stop.
// Parity scenario is built only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CLK_FREQ = 500_000;
  localparam int BAUD     = 9600;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int PAR_ODD  = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // clocks from start-bit drive to the last stop sample:
  // 2 sync + 1 edge + half bit + 1, then one bit time per data/parity/stop bit
  localparam int LAST_SAMPLE = 3 + BIT_CYC / 2 + 1 + BIT_CYC * (8 + PAR_BITS + 1);

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       rx;
  logic       po_ready;
  logic [7:0] po_data;
  logic       po_valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int ferr_n = 0, perr_n = 0, ovr_n = 0, vcyc_n = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #10 sys_clk = ~sys_clk;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY_ODD(PAR_ODD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx),
    .po_data(po_data), .po_valid(po_valid), .po_ready(po_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  always @(negedge sys_clk) begin
    if (po_valid && po_ready) got_q.push_back(po_data);
    if (frame_err) ferr_n++;
    if (parity_err) perr_n++;
    if (overrun) ovr_n++;
    if (po_valid) vcyc_n++;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic par_flip, input int gap);
    @(posedge sys_clk);
    #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CYC) @(posedge sys_clk);
      #1 rx = d[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (BIT_CYC) @(posedge sys_clk);
    #1 rx = (^d) ^ 1'(PAR_ODD) ^ par_flip;
`endif
    repeat (BIT_CYC) @(posedge sys_clk);
    #1 rx = stop_v;
    repeat (BIT_CYC) @(posedge sys_clk);
    #1 rx = 1'b1;
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 40 * BIT_CYC && got_q.size() < n; i++)
      @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; rx = 1'b1; po_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (po_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", po_valid); end
    checks++; if (po_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", po_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int f0, p0, o0, v0;
    logic [7:0] g, e;
    f0 = ferr_n; p0 = perr_n; o0 = ovr_n; v0 = vcyc_n;
    po_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 4);
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL single_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (vcyc_n - v0 != 1) begin errors++; $display("FAIL single_valid_len: got %0d want 1", vcyc_n - v0); end
    checks++; if (ferr_n != f0) begin errors++; $display("FAIL single_ferr: got %0d want %0d", ferr_n, f0); end
    checks++; if (perr_n != p0) begin errors++; $display("FAIL single_perr: got %0d want %0d", perr_n, p0); end
    checks++; if (ovr_n != o0) begin errors++; $display("FAIL single_ovr: got %0d want %0d", ovr_n, o0); end
  endtask

  task automatic test_glitch();
    int f0, v0;
    f0 = ferr_n; v0 = vcyc_n;
    @(posedge sys_clk);
    #1 rx = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1 rx = 1'b1;
    @(negedge sys_clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    repeat (20 * BIT_CYC) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    checks++; if (vcyc_n != v0) begin errors++; $display("FAIL glitch_valid: got %0d want %0d", vcyc_n, v0); end
    checks++; if (ferr_n != f0) begin errors++; $display("FAIL glitch_ferr: got %0d want %0d", ferr_n, f0); end
  endtask

  task automatic test_frame_err();
    int f0, v0;
    logic [7:0] g, e;
    f0 = ferr_n; v0 = vcyc_n;
    po_ready = 1'b1;
    send_frame(8'hA3, 1'b0, 1'b0, 2 * BIT_CYC);
    @(negedge sys_clk);
    checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", ferr_n - f0); end
    checks++; if (vcyc_n != v0) begin errors++; $display("FAIL ferr_valid: got %0d want %0d", vcyc_n, v0); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 4);
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_next_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ferr_next_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL ferr_next_clean: got %0d want 1", ferr_n - f0); end
  endtask

  task automatic test_overrun();
    int o0;
    logic [7:0] g, e;
    o0 = ovr_n;
    po_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0, 4);
    send_frame(8'h34, 1'b1, 1'b0, 4);
    @(negedge sys_clk);
    checks++; if (ovr_n - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", ovr_n - o0); end
    checks++; if (po_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", po_valid); end
    checks++; if (po_data !== 8'h12) begin errors++; $display("FAIL ovr_data_held: got %h want 12", po_data); end
    @(posedge sys_clk);
    #1 po_ready = 1'b1;
    @(negedge sys_clk);
    checks++; if (po_valid !== 1'b1) begin errors++; $display("FAIL ovr_hs_cycle: got %b want 1", po_valid); end
    @(negedge sys_clk);
    checks++; if (po_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b want 0", po_valid); end
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ovr_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_same_cycle();
    int o0;
    logic [7:0] g, e;
    o0 = ovr_n;
    po_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 4);
      begin
        @(posedge sys_clk);
        repeat (LAST_SAMPLE - 1) @(posedge sys_clk);
        #1 po_ready = 1'b1;
        @(negedge sys_clk);
        checks++; if (po_data !== 8'h5A) begin errors++; $display("FAIL same_old: got %h want 5a", po_data); end
        @(negedge sys_clk);
        checks++; if (po_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %b want 1", po_valid); end
        checks++; if (po_data !== 8'hA5) begin errors++; $display("FAIL same_new: got %h want a5", po_data); end
      end
    join
    checks++; if (ovr_n != o0) begin errors++; $display("FAIL same_ovr: got %0d want %0d", ovr_n, o0); end
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL same_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL same_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int f0;
    logic [7:0] g, e, w;
    logic [7:0] pats[4];
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h01; pats[3] = 8'h80;
    f0 = ferr_n;
    po_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      w = (i < 4) ? pats[i] : 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_frame(w, 1'b1, 1'b0, 0);
    end
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (ferr_n != f0) begin errors++; $display("FAIL b2b_ferr: got %0d want %0d", ferr_n, f0); end
  endtask

  task automatic test_reset_mid();
    int f0, p0, o0, v0;
    logic [7:0] g, e, d;
    d = 8'hF0;
    po_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0, 4);
    @(negedge sys_clk);
    checks++; if (po_data !== 8'h99) begin errors++; $display("FAIL rmid_pre_data: got %h want 99", po_data); end
    @(posedge sys_clk);
    #1 rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (BIT_CYC) @(posedge sys_clk);
      #1 rx = d[i];
    end
    repeat (BIT_CYC / 2) @(posedge sys_clk);
    #1 sys_rst = 1'b1; rx = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    f0 = ferr_n; p0 = perr_n; o0 = ovr_n; v0 = vcyc_n;
    checks++; if (po_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", po_valid); end
    checks++; if (po_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", po_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_ferr: got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rmid_perr: got %b want 0", parity_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_ovr: got %b want 0", overrun); end
    repeat (12 * BIT_CYC) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (ferr_n + perr_n + ovr_n + vcyc_n != f0 + p0 + o0 + v0) begin errors++; $display("FAIL rmid_flags: got %0d want %0d", ferr_n + perr_n + ovr_n + vcyc_n, f0 + p0 + o0 + v0); end
    po_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 4);
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rmid_next: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0, v0;
    logic [7:0] g, e;
    p0 = perr_n; v0 = vcyc_n;
    po_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 4);
    @(negedge sys_clk);
    checks++; if (perr_n - p0 != 1) begin errors++; $display("FAIL par_pulse: got %0d want 1", perr_n - p0); end
    checks++; if (vcyc_n != v0) begin errors++; $display("FAIL par_discard: got %0d want %0d", vcyc_n, v0); end
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 4);
    wait_words(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL par_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL par_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (perr_n - p0 != 1) begin errors++; $display("FAIL par_clean: got %0d want 1", perr_n - p0); end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
